// File: rtl/pd_debug_pkg.sv
// Shared constants for the PD debug counter bank:
// read address map, overflow bit order and read FSM states.
package pd_debug_pkg;

  localparam int PACKET_SIZE_WIDTH = 14;

  localparam int A_F1_CNT   = 0;
  localparam int A_F2_CNT   = 1;
  localparam int A_CAP_CNT  = 2;
  localparam int A_TOT_CNT  = 3;
  localparam int A_F1_B_LO  = 4;
  localparam int A_F1_B_HI  = 5;
  localparam int A_F2_B_LO  = 6;
  localparam int A_F2_B_HI  = 7;
  localparam int A_CAP_WORD = 8;
  localparam int A_STATUS   = 9;

  localparam int OVF_F1   = 0;
  localparam int OVF_F2   = 1;
  localparam int OVF_CAP  = 2;
  localparam int OVF_TOT  = 3;
  localparam int OVF_F1_B = 4;
  localparam int OVF_F2_B = 5;
  localparam int NUM_CNT  = 6;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT
  } rd_state_e;

endpackage

// File: rtl/pd_debug_sat_cnt.sv
// Single event counter: add amount on inc, wrap or saturate,
// clear-with-increment loads the increment, ovf_pulse on carry out.
module pd_debug_sat_cnt #(
  parameter int W     = 32,
  parameter int AMT_W = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic [AMT_W-1:0] amount,
  input  logic             clr,
  input  logic             sat_en,
  output logic [W-1:0]     cnt,
  output logic             ovf_pulse
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_base;
  logic [W:0]   w_sum;
  logic [W-1:0] w_next;

  always_comb begin
    w_base    = clr ? '0 : r_cnt;
    w_sum     = {1'b0, w_base} + (W+1)'(amount);
    ovf_pulse = inc & w_sum[W];
    w_next    = w_base;
    if (inc) begin
      w_next = (w_sum[W] && sat_en) ? '1 : w_sum[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_cnt <= '0;
    else       r_cnt <= w_next;
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pd_debug_cnt_bank.sv
// PD debug event counters, sticky capture and a req/ack
// register read port with optional read-to-clear.
module pd_debug_cnt_bank #(
  parameter int PKT_CNT_WIDTH     = 32,
  parameter int BYTE_CNT_WIDTH    = 48,
  parameter int PACKET_SIZE_WIDTH = pd_debug_pkg::PACKET_SIZE_WIDTH,
  parameter int RD_ADDR_WIDTH     = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic dbg2cif_e_debug_pd_field1_cnt_inc,
  input  logic dbg2cif_e_debug_pd_field2_cnt_inc,
  input  logic dbg2cif_e_debug_pd_capture_match_cnt_inc,
  input  logic dbg2cif_e_debug_pd_total_pd_cnt_inc,
  input  logic dbg2cif_e_debug_pd_field1_byte_cnt_inc,
  input  logic dbg2cif_e_debug_pd_field2_byte_cnt_inc,
  input  logic [PACKET_SIZE_WIDTH-1:0]
               dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount,
  input  logic dbg2cif_e_debug_pd_capture_match_field1,
  input  logic dbg2cif_e_debug_pd_capture_match_field2,
  input  logic [31:0] dbg2cif_c_debug_pd_out,
  input  logic cfg_saturate_en,
  input  logic cif_rd_req,
  input  logic [RD_ADDR_WIDTH-1:0] cif_rd_addr,
  input  logic cif_rd_clr,
  output logic cif_rd_ack,
  output logic [31:0] cif_rd_data
);

  import pd_debug_pkg::*;

  rd_state_e r_state;
  rd_state_e w_state_nxt;

  logic [NUM_CNT-1:0]        w_inc;
  logic [NUM_CNT-1:0]        w_clr;
  logic [NUM_CNT-1:0]        w_ovf;
  logic [PKT_CNT_WIDTH-1:0]  w_pcnt [4];
  logic [BYTE_CNT_WIDTH-1:0] w_bcnt [2];

  logic        w_fire;
  logic        w_rclr;
  logic        w_sclr;
  logic [31:0] w_rd_mux;

  logic [NUM_CNT-1:0] r_ovf;
  logic        r_cap_v;
  logic        r_cap_f1;
  logic        r_cap_f2;
  logic [31:0] r_cap_word;
  logic [31:0] r_hi [2];
  logic [31:0] r_rd_data;
  logic        w_cap_v;

  assign w_inc = {
    dbg2cif_e_debug_pd_field2_byte_cnt_inc,
    dbg2cif_e_debug_pd_field1_byte_cnt_inc,
    dbg2cif_e_debug_pd_total_pd_cnt_inc,
    dbg2cif_e_debug_pd_capture_match_cnt_inc,
    dbg2cif_e_debug_pd_field2_cnt_inc,
    dbg2cif_e_debug_pd_field1_cnt_inc
  };

  assign w_fire = (r_state == IDLE) & cif_rd_req;
  assign w_rclr = w_fire & cif_rd_clr;

  always_comb begin
    w_clr = '0;
    w_sclr = 1'b0;
    if (w_rclr) begin
      case (cif_rd_addr)
        RD_ADDR_WIDTH'(A_F1_CNT):  w_clr[OVF_F1]   = 1'b1;
        RD_ADDR_WIDTH'(A_F2_CNT):  w_clr[OVF_F2]   = 1'b1;
        RD_ADDR_WIDTH'(A_CAP_CNT): w_clr[OVF_CAP]  = 1'b1;
        RD_ADDR_WIDTH'(A_TOT_CNT): w_clr[OVF_TOT]  = 1'b1;
        RD_ADDR_WIDTH'(A_F1_B_LO): w_clr[OVF_F1_B] = 1'b1;
        RD_ADDR_WIDTH'(A_F2_B_LO): w_clr[OVF_F2_B] = 1'b1;
        RD_ADDR_WIDTH'(A_STATUS):  w_sclr          = 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_pkt
    pd_debug_sat_cnt #(
      .W(PKT_CNT_WIDTH),
      .AMT_W(1)
    ) u_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .inc      (w_inc[g]),
      .amount   (1'b1),
      .clr      (w_clr[g]),
      .sat_en   (cfg_saturate_en),
      .cnt      (w_pcnt[g]),
      .ovf_pulse(w_ovf[g])
    );
  end

  for (genvar g = 0; g < 2; g++) begin : g_byte
    pd_debug_sat_cnt #(
      .W(BYTE_CNT_WIDTH),
      .AMT_W(PACKET_SIZE_WIDTH)
    ) u_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .inc      (w_inc[4+g]),
      .amount   (dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount),
      .clr      (w_clr[4+g]),
      .sat_en   (cfg_saturate_en),
      .cnt      (w_bcnt[g]),
      .ovf_pulse(w_ovf[4+g])
    );
  end

  // A status clear must not swallow an event landing on the same edge.
  assign w_cap_v = w_sclr ? 1'b0 : r_cap_v;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf      <= '0;
      r_cap_v    <= 1'b0;
      r_cap_f1   <= 1'b0;
      r_cap_f2   <= 1'b0;
      r_cap_word <= '0;
    end else begin
      r_ovf <= (w_sclr ? '0 : r_ovf) | w_ovf;
      if (dbg2cif_e_debug_pd_capture_match_cnt_inc && !w_cap_v) begin
        r_cap_v    <= 1'b1;
        r_cap_f1   <= dbg2cif_e_debug_pd_capture_match_field1;
        r_cap_f2   <= dbg2cif_e_debug_pd_capture_match_field2;
        r_cap_word <= dbg2cif_c_debug_pd_out;
      end else if (w_sclr) begin
        r_cap_v  <= 1'b0;
        r_cap_f1 <= 1'b0;
        r_cap_f2 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hi[0] <= '0;
      r_hi[1] <= '0;
    end else if (w_fire) begin
      if (cif_rd_addr == RD_ADDR_WIDTH'(A_F1_B_LO))
        r_hi[0] <= 32'(w_bcnt[0][BYTE_CNT_WIDTH-1:32]);
      if (cif_rd_addr == RD_ADDR_WIDTH'(A_F2_B_LO))
        r_hi[1] <= 32'(w_bcnt[1][BYTE_CNT_WIDTH-1:32]);
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (cif_rd_addr)
      RD_ADDR_WIDTH'(A_F1_CNT):   w_rd_mux = 32'(w_pcnt[0]);
      RD_ADDR_WIDTH'(A_F2_CNT):   w_rd_mux = 32'(w_pcnt[1]);
      RD_ADDR_WIDTH'(A_CAP_CNT):  w_rd_mux = 32'(w_pcnt[2]);
      RD_ADDR_WIDTH'(A_TOT_CNT):  w_rd_mux = 32'(w_pcnt[3]);
      RD_ADDR_WIDTH'(A_F1_B_LO):  w_rd_mux = w_bcnt[0][31:0];
      RD_ADDR_WIDTH'(A_F1_B_HI):  w_rd_mux = r_hi[0];
      RD_ADDR_WIDTH'(A_F2_B_LO):  w_rd_mux = w_bcnt[1][31:0];
      RD_ADDR_WIDTH'(A_F2_B_HI):  w_rd_mux = r_hi[1];
      RD_ADDR_WIDTH'(A_CAP_WORD): w_rd_mux = r_cap_word;
      RD_ADDR_WIDTH'(A_STATUS):
        w_rd_mux = {23'd0, r_ovf, r_cap_f2, r_cap_f1, r_cap_v};
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_rd_data <= '0;
    else if (w_fire) r_rd_data <= w_rd_mux;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (cif_rd_req) w_state_nxt = ACK;
      ACK:     w_state_nxt = cif_rd_req ? WAIT : IDLE;
      WAIT:    if (!cif_rd_req) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cif_rd_ack  = (r_state == ACK);
    cif_rd_data = r_rd_data;
  end

endmodule
